// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB3 completer with NUM_REGS word registers, WAIT_STATES access wait states and decode-error response.
// Ports: HCLK/HRESETn (clock, async active-low reset); PSEL/PENABLE/PADDR/PWRITE/PWDATA (requester side);
//        PRDATA/PREADY/PSLVERR (completer response). Optional APB_SLAVE_PSTRB_EN adds PSTRB byte strobes.
module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_SLAVE_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);
  localparam int IW = $clog2(NUM_REGS);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [0:0]            r_state;
  logic [IW-1:0]         r_idx;
  logic                  r_wr;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [NB-1:0]         r_strb;
  logic [3:0]            r_cnt;
  logic [IW-1:0]         w_idx;
  logic                  w_err;
  logic                  w_ready;
  logic [NB-1:0]         w_strb;
  assign w_idx   = PADDR[2 +: IW];
  // NUM_REGS is a power of two, so any set bit above the register window means out of range
  assign w_err   = (|PADDR[ADDR_WIDTH-1:IW+2]) | (|PADDR[1:0]);
  assign w_ready = (r_state == S_ACCESS) & PSEL & PENABLE & (r_cnt == 4'd0);
`ifdef APB_SLAVE_PSTRB_EN
  assign w_strb  = PSTRB;
`else
  assign w_strb  = '1;
`endif
  assign PREADY  = w_ready;
  assign PSLVERR = w_ready & r_err;
  assign PRDATA  = (w_ready & ~r_wr) ? r_rdata : '0;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_strb  <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (r_state == S_IDLE) begin
      // setup phase; PSEL&PENABLE without a prior setup is ignored
      if (PSEL && !PENABLE) begin
        r_state <= S_ACCESS;
        r_idx   <= w_idx;
        r_wr    <= PWRITE;
        r_err   <= w_err;
        r_wdata <= PWDATA;
        r_strb  <= w_strb;
        // read data captured now; no write can be pending in IDLE
        r_rdata <= w_err ? '0 : r_regs[w_idx];
        r_cnt   <= 4'(WAIT_STATES);
      end
    end else if (!PSEL) begin
      r_state <= S_IDLE;
    end else if (PENABLE) begin
      if (w_ready) begin
        r_state <= S_IDLE;
        if (r_wr && !r_err)
          for (int b = 0; b < NB; b++)
            if (r_strb[b]) r_regs[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed checks of apb_slave_regfile at WAIT_STATES 0, 2 and 3 sharing one APB bus.
module tb_apb_slave_regfile;
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [2:0]  psel = '0;
  logic        PENABLE = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = 4'hF;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];
  int          vectors = 0;
  int          errs = 0;
  always #5 HCLK = ~HCLK;
  apb_slave_regfile #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(psel[0]), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA),
`ifdef APB_SLAVE_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
  apb_slave_regfile #(.WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(psel[1]), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA),
`ifdef APB_SLAVE_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
  apb_slave_regfile #(.WAIT_STATES(3)) u_ws3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(psel[2]), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA),
`ifdef APB_SLAVE_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // drives setup right after the previous completion edge, so consecutive calls are back-to-back
  task automatic xfer(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er, output int n);
    @(posedge HCLK); #1;
    psel = '0; psel[k] = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PWDATA = d; PSTRB = s;
    @(posedge HCLK); #1;
    PENABLE = 1'b1; n = 1;
    @(negedge HCLK);
    while (!pready[k] && n < 20) begin
      chk("wait_prdata_zero", prdata[k], 32'h0);
      chk("wait_pslverr_zero", {31'b0, pslverr[k]}, 32'h0);
      @(posedge HCLK); #1; n++;
      @(negedge HCLK);
    end
    rd = prdata[k];
    er = pslverr[k];
  endtask
  task automatic run(input string tag, input int k, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp_rd, input logic exp_er, input int exp_n);
    logic [31:0] rd;
    logic        er;
    int          n;
    xfer(k, wr, a, d, s, rd, er, n);
    chk({tag, "_prdata"}, rd, exp_rd);
    chk({tag, "_pslverr"}, {31'b0, er}, {31'b0, exp_er});
    chk({tag, "_cycles"}, n, exp_n);
  endtask
  initial begin
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    for (int k = 0; k < 3; k++) begin
      chk("reset_pready", {31'b0, pready[k]}, 32'h0);
      chk("reset_pslverr", {31'b0, pslverr[k]}, 32'h0);
      chk("reset_prdata", prdata[k], 32'h0);
    end
    @(posedge HCLK); #1;
    psel[0] = 1'b1; PENABLE = 1'b1; PADDR = 32'h0;
    @(negedge HCLK); chk("no_setup_pready_a", {31'b0, pready[0]}, 32'h0);
    @(negedge HCLK); chk("no_setup_pready_b", {31'b0, pready[0]}, 32'h0);
    @(posedge HCLK); #1;
    psel = '0; PENABLE = 1'b0;
    run("ws0_wr08", 0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1);
    run("ws0_rd08", 0, 1'b0, 32'h08, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1);
    run("ws0_wr3c", 0, 1'b1, 32'h3C, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 1);
    run("ws0_rd3c", 0, 1'b0, 32'h3C, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, 1);
    run("ws0_rd08b", 0, 1'b0, 32'h08, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1);
    run("ws3_wr04", 2, 1'b1, 32'h04, 32'h12345678, 4'hF, 32'h0, 1'b0, 4);
    run("ws3_rd04", 2, 1'b0, 32'h04, 32'h0, 4'hF, 32'h12345678, 1'b0, 4);
    run("err_wr40", 1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 3);
    run("err_rd40", 1, 1'b0, 32'h40, 32'h0, 4'hF, 32'h0, 1'b1, 3);
    run("err_rd06", 1, 1'b0, 32'h06, 32'h0, 4'hF, 32'h0, 1'b1, 3);
    for (int i = 0; i < 16; i++)
      run("err_scan", 1, 1'b0, 32'(i * 4), 32'h0, 4'hF, 32'h0, 1'b0, 3);
    @(posedge HCLK); #1;
    psel = 3'b010; PENABLE = 1'b0; PADDR = 32'h0C; PWRITE = 1'b1; PWDATA = 32'hA5A5A5A5;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(negedge HCLK); chk("abort_pready", {31'b0, pready[1]}, 32'h0);
    @(posedge HCLK); #1;
    psel = '0; PENABLE = 1'b0;
    run("abort_rd0c", 1, 1'b0, 32'h0C, 32'h0, 4'hF, 32'h0, 1'b0, 3);
    @(posedge HCLK); #1;
    psel = 3'b001; PENABLE = 1'b0; PADDR = 32'h00; PWRITE = 1'b1; PWDATA = 32'hCAFEF00D;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    #2 chk("rst_pre_pready", {31'b0, pready[0]}, 32'h1);
    HRESETn = 1'b0;
    #1;
    chk("rst_pready", {31'b0, pready[0]}, 32'h0);
    chk("rst_pslverr", {31'b0, pslverr[0]}, 32'h0);
    chk("rst_prdata", prdata[0], 32'h0);
    @(posedge HCLK); #1;
    psel = '0; PENABLE = 1'b0;
    #2 HRESETn = 1'b1;
    run("rst_rd00", 0, 1'b0, 32'h00, 32'h0, 4'hF, 32'h0, 1'b0, 1);
    run("rst_rd08", 0, 1'b0, 32'h08, 32'h0, 4'hF, 32'h0, 1'b0, 1);
`ifdef APB_SLAVE_PSTRB_EN
    run("strb_full", 0, 1'b1, 32'h10, 32'h11223344, 4'b1111, 32'h0, 1'b0, 1);
    run("strb_part", 0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1);
    run("strb_none", 0, 1'b1, 32'h10, 32'h99999999, 4'b0000, 32'h0, 1'b0, 1);
    run("strb_rd10", 0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0, 1);
`endif
    @(posedge HCLK); #1;
    psel = '0; PENABLE = 1'b0;
    repeat (2) @(posedge HCLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB3 completer placed directly downstream of the AHB-to-APB bridge.
- Consumes PSEL/PENABLE/PADDR/PWRITE/PWDATA and returns PRDATA, PREADY and PSLVERR.
- Provides a bank of NUM_REGS read/write registers, with a parameterised number of wait states and address-error signalling.
- Serves as the reference completer for bridge integration and bridge SVA runs.

Parameters:
- ADDR_WIDTH, 32: PADDR width.
- DATA_WIDTH, 32: data width. Must be 32; registers are word-aligned (byte offset in PADDR[1:0]).
- NUM_REGS, 16: number of 32-bit registers. Power of two, 2..256.
- WAIT_STATES, 0: extra ACCESS-phase cycles before PREADY is asserted. Range 0..15.

Ports:
- HCLK  in  1  clock; all state updates on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  completer select.
- PENABLE  in  1  access-phase indicator.
- PADDR  in  ADDR_WIDTH  byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data; valid only while PREADY=1 on a read.
- PREADY  out  1  transfer completes on the edge where PSEL&PENABLE&PREADY.
- PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Reset: reset is asynchronous and active-low (HRESETn); single clock HCLK.
  - On reset: all registers = 0, state = IDLE, wait counter = 0, latched fields = 0.
  - Outputs PRDATA = 0, PREADY = 0, PSLVERR = 0 (combinational from IDLE).
- FSM states: IDLE, ACCESS.
- IDLE:
  - On an edge with PSEL=1 and PENABLE=0 (setup phase), latch the following, then go to ACCESS:
    - addr_q <= PADDR; wr_q <= PWRITE; wdata_q <= PWDATA.
    - err_q <= decode error.
    - rdata_q <= reg[idx], or 0 on error.
    - cnt <= WAIT_STATES.
  - PSEL=1 with PENABLE=1 while in IDLE (no setup seen) is ignored. PREADY stays 0 and no state changes.
- ACCESS:
  - PREADY = PSEL & PENABLE & (cnt==0).
  - Edge with PSEL & PENABLE & !PREADY: cnt <= cnt-1.
  - Edge with PSEL & PENABLE & PREADY: transfer completes.
    - If wr_q & !err_q: reg[idx] <= wdata_q.
    - state <= IDLE.
  - Edge with PSEL=0: abort. state <= IDLE, no register update.
- Latency: setup 1 cycle plus access WAIT_STATES+1 cycles. WAIT_STATES=0 gives the 2-cycle APB transfer the bridge issues.
- Back-to-back: a new setup phase in the cycle after completion is accepted normally; there are no idle cycles between transfers.
- Decode: idx = addr[2 +: log2(NUM_REGS)]. Error if either holds:
  - addr >= NUM_REGS*4, or
  - addr[1:0] != 0.
- Error transfers: reads return PRDATA = 0 and writes are dropped. PSLVERR = PREADY & err_q.
- PRDATA = (PREADY & !wr_q) ? rdata_q : 0.
- Read data is sampled in the setup phase. This is coherent because the block holds no pending write at that point.
- Reset mid-transfer: immediate return to IDLE, outputs 0. A pending write is not committed.

Optional Feature:
- Macro: APB_SLAVE_PSTRB_EN.
- Defined:
  - Adds input PSTRB [DATA_WIDTH/8-1:0], latched in the setup phase.
  - On write completion only the bytes with PSTRB[i]=1 are updated.
  - A write with PSTRB = 0 completes with PREADY and no change.
  - Reads ignore PSTRB.
- Undefined: no PSTRB port; writes always update the full word.

Test Plan:
- WAIT_STATES=0:
  - Stimulus: write 0xDEADBEEF to 0x08, then read 0x08.
  - Required: PREADY in the cycle after setup, PRDATA = 0xDEADBEEF, PSLVERR = 0, each transfer 2 cycles.
- WAIT_STATES=3:
  - Stimulus: read of 0x04 after writing 0x12345678 there.
  - Required: PREADY low for 3 access cycles and high on the 4th, PRDATA = 0x12345678 only while PREADY=1, 0 otherwise.
- NUM_REGS=16:
  - Stimulus: write 0xFFFFFFFF to 0x40, then read 0x40; also read 0x06.
  - Required: PSLVERR = 1 with PREADY on each, PRDATA = 0, and all registers still 0 after the write.
- WAIT_STATES=2:
  - Stimulus: write 0xA5A5A5A5 to 0x0C, drop PSEL after the 1st access cycle; then read 0x0C.
  - Required: returns 0, FSM back in IDLE, the next setup is accepted.
- Reset mid-access:
  - Stimulus: assert HRESETn=0 during the access phase of a write to 0x00.
  - Required: PREADY/PSLVERR/PRDATA = 0 immediately; the subsequent read of 0x00 returns 0.
- APB_SLAVE_PSTRB_EN:
  - Stimulus: write 0x11223344 with PSTRB=4'b1111 to 0x10, then 0xAABBCCDD with PSTRB=4'b0101.
  - Required: read of 0x10 returns 0x11BB33DD.
